// File: rtl/fb_scanout_scaler.sv
// fb_scanout_scaler: turns the HDMI raster position (cx, cy) into framebuffer
// reads for an integer-scaled window, and turns the returned pixel indices into
// 24-bit RGB. Everything outside the window shows a per-frame border colour.
module fb_scanout_scaler #(
    parameter int SRC_W     = 160,
    parameter int SRC_H     = 120,
    parameter int PIX_BITS  = 3,
    parameter int SCALE_X   = 4,
    parameter int SCALE_Y   = 4,
    parameter int CXY_BITS  = 12,
    parameter int MEM_LAT   = 1,
    parameter int ADDR_BITS = $clog2(SRC_W * SRC_H)
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic [CXY_BITS-1:0]  cx,
    input  logic [CXY_BITS-1:0]  cy,
    input  logic [CXY_BITS-1:0]  win_x,
    input  logic [CXY_BITS-1:0]  win_y,
    input  logic                 mode,
    input  logic [23:0]          border_rgb,
    input  logic                 pal_we,
    input  logic [PIX_BITS-1:0]  pal_idx,
    input  logic [23:0]          pal_data,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic                 fb_ce,
    input  logic [PIX_BITS-1:0]  fb_dout,
    output logic [23:0]          rgb,
    output logic                 win_active
);

    localparam int WIDE  = CXY_BITS + 4;
    localparam int PAL_N = 2 ** PIX_BITS;
    localparam int DEPTH = MEM_LAT + 1;
    localparam logic [WIDE-1:0]      WIN_W    = WIDE'(SRC_W * SCALE_X);
    localparam logic [WIDE-1:0]      WIN_H    = WIDE'(SRC_H * SCALE_Y);
    localparam logic [2:0]           H_LAST   = 3'(SCALE_X - 1);
    localparam logic [2:0]           V_LAST   = 3'(SCALE_Y - 1);
    localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(SRC_W);
    localparam logic [ADDR_BITS-1:0] ONE      = ADDR_BITS'(1);
    localparam int IG = (PIX_BITS >= 2) ? PIX_BITS - 2 : 0;
    localparam int IB = (PIX_BITS >= 3) ? PIX_BITS - 3 : 0;

    // Direct expansion: 3-bit pixels are one bit per channel, anything else is
    // a grey level with the index MSB-aligned and repeated down to bit 0.
    function automatic logic [23:0] expand(input logic [PIX_BITS-1:0] p);
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < 8; i++) g[7-i] = p[PIX_BITS-1-(i % PIX_BITS)];
        if (PIX_BITS == 3) return {{8{p[PIX_BITS-1]}}, {8{p[IG]}}, {8{p[IB]}}};
        return {g, g, g};
    endfunction

    // Per-frame configuration, captured only on the frame-start pixel.
    logic [CXY_BITS-1:0] win_x_q, win_y_q;
    logic                mode_q;
    logic [23:0]         border_q;
    logic                frame_valid;   // a frame start has been seen since reset

    // The frame-start pixel already belongs to the new frame, so it uses the
    // live inputs rather than last frame's copies.
    logic                frame_start;
    logic [CXY_BITS-1:0] wx_eff, wy_eff;
    logic                mode_eff;
    logic [23:0]         border_eff;

    assign frame_start = (cx == '0) && (cy == '0);
    assign wx_eff      = frame_start ? win_x      : win_x_q;
    assign wy_eff      = frame_start ? win_y      : win_y_q;
    assign mode_eff    = frame_start ? mode       : mode_q;
    assign border_eff  = frame_start ? border_rgb : border_q;

    // Incremental address state.
    logic [ADDR_BITS-1:0] row_base, col_addr;
    logic [2:0]           h_sub, v_sub;
    logic                 line_pending;   // an earlier window line exists this frame

    logic                 in_win, first_px;
    logic [ADDR_BITS-1:0] base_sel;
    logic [2:0]           v_sel;

    // Window test at widened precision, plus the row to use on a line's first
    // window pixel. The previous line's vertical step is applied here, so a
    // window clipped on the right still advances rows correctly.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        in_win   = 1'b0;
        first_px = 1'b0;
        base_sel = row_base;
        v_sel    = v_sub;
        if (frame_start || frame_valid) begin
            in_win = (WIDE'(cx) >= WIDE'(wx_eff)) && (WIDE'(cx) < WIDE'(wx_eff) + WIN_W) &&
                     (WIDE'(cy) >= WIDE'(wy_eff)) && (WIDE'(cy) < WIDE'(wy_eff) + WIN_H);
        end
        first_px = in_win && (cx == wx_eff);
        if (frame_start) begin
            base_sel = '0;
            v_sel    = '0;
        end else if (line_pending) begin
            if (v_sub == V_LAST) begin
                base_sel = row_base + ROW_STEP;
                v_sel    = '0;
            end else begin
                v_sel = v_sub + 3'd1;
            end
        end
    end

    // Capture the frame configuration on the frame-start pixel.
    // NOTE: the reset is in the sensitivity list, so clearing is asynchronous.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            win_x_q     <= '0;
            win_y_q     <= '0;
            mode_q      <= 1'b0;
            border_q    <= '0;
            frame_valid <= 1'b0;
        end else if (frame_start) begin
            win_x_q     <= win_x;
            win_y_q     <= win_y;
            mode_q      <= mode;
            border_q    <= border_rgb;
            frame_valid <= 1'b1;
        end
    end

    // Walk the source address: new row at each line's first window pixel,
    // horizontal replication within the line.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            row_base     <= '0;
            col_addr     <= '0;
            h_sub        <= '0;
            v_sub        <= '0;
            line_pending <= 1'b0;
        end else begin
            if (frame_start) begin
                row_base     <= '0;
                v_sub        <= '0;
                line_pending <= 1'b0;
            end
            if (first_px) begin
                row_base     <= base_sel;
                v_sub        <= v_sel;
                col_addr     <= base_sel;
                h_sub        <= '0;
                line_pending <= 1'b1;
            end else if (in_win) begin
                if (h_sub == H_LAST) begin
                    h_sub    <= '0;
                    col_addr <= col_addr + ONE;
                end else begin
                    h_sub <= h_sub + 3'd1;
                end
            end
        end
    end

    assign fb_addr = col_addr;

    // Carry window flag, mode and border alongside the memory read.
    logic        win_pipe    [DEPTH];
    logic        mode_pipe   [DEPTH];
    logic [23:0] border_pipe [DEPTH];

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_pipe[i]    <= 1'b0;
                mode_pipe[i]   <= 1'b0;
                border_pipe[i] <= '0;
            end
        end else begin
            win_pipe[0]    <= in_win;
            mode_pipe[0]   <= mode_eff;
            border_pipe[0] <= border_eff;
            for (int i = 1; i < DEPTH; i++) begin
                win_pipe[i]    <= win_pipe[i-1];
                mode_pipe[i]   <= mode_pipe[i-1];
                border_pipe[i] <= border_pipe[i-1];
            end
        end
    end

    assign fb_ce = win_pipe[0];

    // Palette, writable at any time; resets to the direct-expansion colours.
    logic [23:0] palette [PAL_N];

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            // NOTE: this small register-file palette is reset on purpose so that
            // palette mode shows defined colours before software loads it.
            for (int i = 0; i < PAL_N; i++) palette[i] <= expand(PIX_BITS'(i));
        end else if (pal_we) begin
            palette[pal_idx] <= pal_data;
        end
    end

    // Final colour select; a same-cycle palette write is seen one cycle later.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            rgb        <= '0;
            win_active <= 1'b0;
        end else if (win_pipe[DEPTH-1]) begin
            rgb        <= mode_pipe[DEPTH-1] ? palette[fb_dout] : expand(fb_dout);
            win_active <= 1'b1;
        end else begin
            rgb        <= border_pipe[DEPTH-1];
            win_active <= 1'b0;
        end
    end

endmodule

// File: doc/fb_scanout_scaler.md
FB_SCANOUT_SCALER -- requirements
Module: fb_scanout_scaler

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- SRC_W, 160: source framebuffer width in pixels.
- SRC_H, 120: source framebuffer height in lines.
- PIX_BITS, 3: bits per stored pixel.
- SCALE_X, 4: integer horizontal replication, range 1..8.
- SCALE_Y, 4: integer vertical replication, range 1..8.
- CXY_BITS, 12: width of the cx/cy counters.
- MEM_LAT, 1: framebuffer read latency in clk_pixel cycles, range 1..2.
- ADDR_BITS, $clog2(SRC_W*SRC_H): width of the framebuffer address.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk_pixel, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high reset.
- cx, in, CXY_BITS: current HDMI pixel column.
- cy, in, CXY_BITS: current HDMI pixel line.
- win_x, in, CXY_BITS: window left edge; latched per frame.
- win_y, in, CXY_BITS: window top edge; latched per frame.
- mode, in, 1: 0 = direct expand, 1 = palette; latched per frame.
- border_rgb, in, 24: colour shown outside the window; latched per frame.
- pal_we, in, 1: palette write strobe.
- pal_idx, in, PIX_BITS: palette write index.
- pal_data, in, 24: palette write data.
- fb_addr, out, ADDR_BITS: framebuffer read address.
- fb_ce, out, 1: framebuffer read enable.
- fb_dout, in, PIX_BITS: framebuffer read data, valid MEM_LAT cycles after fb_addr.
- rgb, out, 24: output pixel, {R,G,B}.
- win_active, out, 1: rgb holds framebuffer content, not border.

Function
REQ-003 Frame start SHALL be the cycle with cx==0 and cy==0; win_x, win_y, mode and border_rgb SHALL be captured on that cycle only, and the captured copies used for the whole frame.
REQ-004 A pixel is in the window iff win_x <= cx < win_x+SRC_W*SCALE_X and win_y <= cy < win_y+SRC_H*SCALE_Y; the sums SHALL be computed at CXY_BITS+4 bits, so there is no wrap-around. A window extending past the screen SHALL be clipped, with no address corruption on the next frame.
REQ-005 Address generation SHALL be incremental, with no multiplier:
- Registers: row_base, h_sub (0..SCALE_X-1), v_sub (0..SCALE_Y-1), col_addr.
- Frame start: row_base=0, v_sub=0.
- First window pixel of each line: col_addr=row_base, h_sub=0.
- Each further window pixel: h_sub increments; on wrap, col_addr increments.
- Last window pixel of a line: v_sub increments; on wrap to 0, row_base += SRC_W.
REQ-006 fb_addr SHALL be registered and valid one cycle after cx/cy; fb_ce SHALL be 1 only for in-window pixels.
REQ-007 Total latency from cx/cy to rgb and win_active SHALL be exactly MEM_LAT+2 cycles. The in-window flag and the captured border colour SHALL be delayed through a matching shift register.
REQ-008 Mode 0 with PIX_BITS==3: bit2 selects R, bit1 G, bit0 B, each expanding to 8'hFF or 8'h00. Mode 0 with any other PIX_BITS: grayscale, with the index MSB-aligned and bit-replicated into 8 bits, same value on all three channels.
REQ-009 Mode 1 SHALL output palette[fb_dout]. The palette has 2**PIX_BITS entries of 24 bits and is written on any cycle with pal_we=1.
REQ-010 A palette write and a read of the same index in the same cycle SHALL return the old entry; the new value is visible from the next cycle.
REQ-011 Outside the window, rgb SHALL equal the latched border_rgb and win_active SHALL be 0.
REQ-012 cx/cy jumping off-sequence (e.g. a new frame start mid-frame) SHALL restart address generation at row_base=0 from that frame start, with no lock-up.

Reset
REQ-013 While reset=1, asynchronously:
- rgb=0, win_active=0, fb_addr=0, fb_ce=0.
- row_base, col_addr, h_sub, v_sub = 0.
- Latched config: win_x=0, win_y=0, mode=0, border_rgb=0.
- Pipeline flags cleared.
- Palette entry i = mode-0 expansion of i.
REQ-014 After reset deasserts mid-frame, outputs SHALL stay border (rgb=0, win_active=0) until the first frame start.

Verification
REQ-015 Defaults, win=(0,0), mode 0, scan a full 1280x720 frame:
- Pixel (0,0) -> fb_addr=0 at cycle 1.
- Pixel (4,0) -> fb_addr=1.
- Pixel (0,4) -> fb_addr=160.
- Pixel (639,479) -> fb_addr=19199.
- Pixel (640,0) -> fb_ce=0 and rgb=border.
REQ-016 fb_dout=3'b101 at (0,0), MEM_LAT=1, mode 0 -> rgb=24'hFF00FF and win_active=1 exactly 3 cycles after cx=0,cy=0.
REQ-017 Mode 1 with pal_idx=5, pal_data=24'h123456 written before the frame, fb_dout=5 -> rgb=24'h123456. A same-cycle write of index 5 during that read -> the old value appears.
REQ-018 win_x changed from 0 to 100 mid-frame -> no effect until the next frame start; from then, pixel (100,0) -> fb_addr=0 and pixel (99,0) -> border.
REQ-019 win_x=1200, SCALE_X=4 -> the window is clipped at cx=1279 and fb_addr on the next frame starts at 0.
REQ-020 reset pulsed at (300,200) -> all outputs 0 immediately; rgb=0 until the next (0,0); normal addressing resumes after it.
